// File: rtl/cicero_job_sequencer.sv
// Job driver for a bank of CICERO engine register files: writes a job's words,
// starts the selected engine, collects its verdict and elapsed clocks.

module cicero_cmd_lane #(
    parameter int                   REG_WIDTH = 32,
    parameter int                   ENG_W     = 2,
    parameter int                   LANE      = 0,
    parameter logic [REG_WIDTH-1:0] NOP_VAL   = '0
) (
    input  logic [ENG_W-1:0]     eng_sel,
    input  logic [REG_WIDTH-1:0] cmd,
    output logic [REG_WIDTH-1:0] lane_cmd
);
    assign lane_cmd = (eng_sel == ENG_W'(LANE)) ? cmd : NOP_VAL;
endmodule

module cicero_job_sequencer #(
    parameter int REG_WIDTH   = 32,
    parameter int NUM_ENGINES = 4,
    parameter int TIMEOUT_CC  = 65535,
    localparam int ENG_W      = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             job_valid,
    output logic                             job_ready,
    input  logic [ENG_W-1:0]                 job_engine,
    input  logic [REG_WIDTH-1:0]             job_base_addr,
    input  logic [REG_WIDTH-1:0]             job_start_ptr,
    input  logic [REG_WIDTH-1:0]             job_end_ptr,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [REG_WIDTH-1:0]             ld_data,
    input  logic                             ld_last,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ENG_W-1:0]                 res_engine,
    output logic [1:0]                       res_status,
    output logic [REG_WIDTH-1:0]             res_cc,
    output logic [REG_WIDTH-1:0]             eng_address,
    output logic [REG_WIDTH-1:0]             eng_data_in,
    output logic [REG_WIDTH-1:0]             eng_start_ptr,
    output logic [REG_WIDTH-1:0]             eng_end_ptr,
    output logic [NUM_ENGINES*REG_WIDTH-1:0] eng_cmd,
    input  logic [NUM_ENGINES*REG_WIDTH-1:0] eng_status,
    input  logic [NUM_ENGINES*REG_WIDTH-1:0] eng_data_o
);
    localparam int TW = $clog2(TIMEOUT_CC + 1);

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(2);
    localparam logic [REG_WIDTH-1:0] CMD_RESET              = REG_WIDTH'(3);
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(4);
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING         = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED        = REG_WIDTH'(2);
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED        = REG_WIDTH'(3);

    typedef enum logic [3:0] {
        IDLE, W_ADDR, W_DATA, W_CMD, W_NOP, DRAIN, S_PTR, S_CMD,
        S_CHK, WAIT, ELAPSED, E_CAP, ABORT, A_NOP, RESP
    } state_t;

    state_t               state, state_d;
    logic                 armed;
    logic [ENG_W-1:0]     eng_sel, eng_sel_d;
    logic [REG_WIDTH-1:0] sp, sp_d, ep, ep_d, wa, wa_d, word_q, word_d;
    logic                 last_q, last_d;
    logic [REG_WIDTH-1:0] addr_d, din_d, sptr_d, eptr_d, cmd_q, cmd_d, res_cc_d;
    logic [TW-1:0]        timer, timer_d;
    logic [1:0]           res_status_d;
    logic [REG_WIDTH-1:0] sel_status, sel_data;
    logic                 job_eng_ok;

    assign job_eng_ok = (32'(job_engine) < 32'(NUM_ENGINES));
    assign job_ready  = (state == IDLE) && armed;
    assign ld_ready   = (state == W_ADDR) || (state == DRAIN);
    assign res_valid  = (state == RESP);
    assign res_engine = eng_sel;

    always_comb begin
        sel_status = '0;
        sel_data   = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (eng_sel == ENG_W'(i)) begin
                sel_status = eng_status[i*REG_WIDTH +: REG_WIDTH];
                sel_data   = eng_data_o[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Only the selected lane ever sees cmd_q; everyone else idles on NOP.
    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_lane
        cicero_cmd_lane #(
            .REG_WIDTH(REG_WIDTH), .ENG_W(ENG_W), .LANE(g), .NOP_VAL(CMD_NOP)
        ) u_lane (
            .eng_sel  (eng_sel),
            .cmd      (cmd_q),
            .lane_cmd (eng_cmd[g*REG_WIDTH +: REG_WIDTH])
        );
    end

    always_comb begin
        state_d      = state;
        eng_sel_d    = eng_sel;
        sp_d         = sp;
        ep_d         = ep;
        wa_d         = wa;
        word_d       = word_q;
        last_d       = last_q;
        addr_d       = eng_address;
        din_d        = eng_data_in;
        sptr_d       = eng_start_ptr;
        eptr_d       = eng_end_ptr;
        cmd_d        = cmd_q;
        timer_d      = timer;
        res_status_d = res_status;
        res_cc_d     = res_cc;
        case (state)
            IDLE: if (job_valid && job_ready) begin
                eng_sel_d    = job_engine;
                sp_d         = job_start_ptr;
                ep_d         = job_end_ptr;
                wa_d         = job_base_addr >> 2;
                res_status_d = 2'd2;
                res_cc_d     = '0;
                state_d      = job_eng_ok ? W_ADDR : DRAIN;
            end
            W_ADDR: if (ld_valid) begin
                addr_d  = wa;
                word_d  = ld_data;
                last_d  = ld_last;
                state_d = W_DATA;
            end
            W_DATA: begin
                din_d   = word_q;
                state_d = W_CMD;
            end
            W_CMD: begin
                cmd_d   = CMD_WRITE;
                state_d = W_NOP;
            end
            W_NOP: begin
                cmd_d   = CMD_NOP;
                wa_d    = wa + REG_WIDTH'(1);
                state_d = last_q ? S_PTR : W_ADDR;
            end
            // Unknown engine: swallow the word stream, then report start_fail.
            DRAIN: if (ld_valid && ld_last) state_d = RESP;
            S_PTR: begin
                sptr_d  = sp;
                eptr_d  = ep;
                timer_d = '0;
                state_d = S_CMD;
            end
            S_CMD: begin
                cmd_d   = CMD_START;
                timer_d = timer + TW'(1);
                if (timer == TW'(2)) state_d = S_CHK;
            end
            S_CHK: begin
                if (sel_status == STATUS_RUNNING) begin
                    cmd_d   = CMD_NOP;
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    res_status_d = 2'd2;
                    state_d      = ABORT;
                end
            end
            WAIT: begin
                timer_d = timer + TW'(1);
                if (sel_status == STATUS_ACCEPTED) begin
                    res_status_d = 2'd0;
                    state_d      = ELAPSED;
                end else if (sel_status == STATUS_REJECTED) begin
                    res_status_d = 2'd1;
                    state_d      = ELAPSED;
                end else if (timer + TW'(1) == TW'(TIMEOUT_CC)) begin
                    res_status_d = 2'd3;
                    state_d      = ABORT;
                end else if (sel_status != STATUS_RUNNING) begin
                    res_status_d = 2'd2;
                    state_d      = ABORT;
                end
            end
            ELAPSED: begin
                cmd_d   = CMD_READ_ELAPSED_CLOCK;
                state_d = E_CAP;
            end
            E_CAP: begin
                cmd_d    = CMD_NOP;
                res_cc_d = sel_data;
                state_d  = RESP;
            end
            ABORT: begin
                cmd_d   = CMD_RESET;
                state_d = A_NOP;
            end
            A_NOP: begin
                cmd_d    = CMD_NOP;
                res_cc_d = '0;
                state_d  = RESP;
            end
            RESP: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            armed         <= 1'b0;
            eng_sel       <= '0;
            sp            <= '0;
            ep            <= '0;
            wa            <= '0;
            word_q        <= '0;
            last_q        <= 1'b0;
            eng_address   <= '0;
            eng_data_in   <= '0;
            eng_start_ptr <= '0;
            eng_end_ptr   <= '0;
            cmd_q         <= CMD_NOP;
            timer         <= '0;
            res_status    <= '0;
            res_cc        <= '0;
        end else begin
            state         <= state_d;
            armed         <= 1'b1;
            eng_sel       <= eng_sel_d;
            sp            <= sp_d;
            ep            <= ep_d;
            wa            <= wa_d;
            word_q        <= word_d;
            last_q        <= last_d;
            eng_address   <= addr_d;
            eng_data_in   <= din_d;
            eng_start_ptr <= sptr_d;
            eng_end_ptr   <= eptr_d;
            cmd_q         <= cmd_d;
            timer         <= timer_d;
            res_status    <= res_status_d;
            res_cc        <= res_cc_d;
        end
    end
endmodule

// File: tb/tb_cicero_job_sequencer.sv
// Directed + randomized bench: behavioural engine models per lane, a write log,
// and expected results derived from the job parameters.

module tb_cicero_job_sequencer;
    localparam int RW = 32, NE = 4, TO = 100, EW = 2, LIM = 2000;
    localparam logic [31:0] C_NOP = 0, C_WRITE = 1, C_START = 2, C_RESET = 3, C_READ = 4;
    localparam logic [31:0] S_IDLE = 0, S_RUN = 1, S_ACC = 2, S_REJ = 3;
    // engine behaviours
    localparam int M_ACC = 0, M_REJ = 1, M_STUCK = 2, M_DEAD = 3;

    logic clk = 1'b0, rst = 1'b0;
    logic job_valid = 0, job_ready, ld_valid = 0, ld_ready, ld_last = 0, res_valid, res_ready = 0;
    logic [EW-1:0] job_engine = '0, res_engine;
    logic [RW-1:0] job_base_addr = '0, job_start_ptr = '0, job_end_ptr = '0, ld_data = '0;
    logic [1:0]    res_status;
    logic [RW-1:0] res_cc, eng_address, eng_data_in, eng_start_ptr, eng_end_ptr;
    logic [NE*RW-1:0] eng_cmd, eng_status, eng_data_o;

    always #5 clk = ~clk;

    cicero_job_sequencer #(.REG_WIDTH(RW), .NUM_ENGINES(NE), .TIMEOUT_CC(TO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_engine(job_engine),
        .job_base_addr(job_base_addr), .job_start_ptr(job_start_ptr), .job_end_ptr(job_end_ptr),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_engine(res_engine),
        .res_status(res_status), .res_cc(res_cc),
        .eng_address(eng_address), .eng_data_in(eng_data_in),
        .eng_start_ptr(eng_start_ptr), .eng_end_ptr(eng_end_ptr),
        .eng_cmd(eng_cmd), .eng_status(eng_status), .eng_data_o(eng_data_o)
    );

    int vectors = 0, miscompares = 0;

    // engine models + command monitor, sampled mid-cycle
    int          mode [NE];
    int          delay[NE];
    logic [31:0] dval [NE];
    logic [31:0] st   [NE];
    int          cnt  [NE];
    int cyc = 0, cur_eng = 0, other_bad = 0, reset_cnt = 0, last_start_cyc = 0, reset_cyc = 0;
    logic [31:0] wr_addr[$], wr_data[$];
    int          wr_cyc[$];

    always_comb begin
        eng_status = '0;
        eng_data_o = '0;
        for (int i = 0; i < NE; i++) begin
            eng_status[i*RW +: RW] = st[i];
            eng_data_o[i*RW +: RW] = dval[i];
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NE; i++) begin
            if (!rst) begin
                st[i]  <= S_IDLE;
                cnt[i] <= 0;
            end else begin
                if (eng_cmd[i*RW +: RW] != C_NOP && i != cur_eng) other_bad <= other_bad + 1;
                if (eng_cmd[i*RW +: RW] == C_WRITE) begin
                    wr_addr.push_back(eng_address);
                    wr_data.push_back(eng_data_in);
                    wr_cyc.push_back(cyc);
                end
                if (eng_cmd[i*RW +: RW] == C_RESET) begin
                    reset_cnt <= reset_cnt + 1;
                    reset_cyc <= cyc;
                    st[i]     <= S_IDLE;
                end else if (eng_cmd[i*RW +: RW] == C_START) begin
                    last_start_cyc <= cyc;
                    if (mode[i] != M_DEAD) begin
                        st[i]  <= S_RUN;
                        cnt[i] <= delay[i];
                    end
                end else if (st[i] == S_RUN && (mode[i] == M_ACC || mode[i] == M_REJ)) begin
                    if (cnt[i] == 0) st[i] <= (mode[i] == M_ACC) ? S_ACC : S_REJ;
                    else             cnt[i] <= cnt[i] - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input int eng, input logic [31:0] base, input int nw, input int md,
                           input int dly, input logic [31:0] dv, input int gap_at,
                           input int gap_len, input int hold, input bit fixed);
        logic [31:0] words[$];
        logic [31:0] sp, ep, wa0;
        int wbase, rbase, t;
        logic [1:0]  exp_st;
        logic [31:0] exp_cc;
        bit stable;
        cur_eng = eng; mode[eng] = md; delay[eng] = dly; dval[eng] = dv;
        for (int k = 0; k < nw; k++) words.push_back(fixed ? 32'hA + k : $urandom);
        sp = $urandom; ep = $urandom; wa0 = base >> 2;
        wbase = wr_addr.size(); rbase = reset_cnt;

        job_valid = 1; job_engine = EW'(eng); job_base_addr = base;
        job_start_ptr = sp; job_end_ptr = ep;
        t = 0;
        while (!job_ready && t < LIM) begin @(negedge clk); t++; end
        check("job_hs_bound", t < LIM, 1);
        @(posedge clk); #1 job_valid = 0;

        for (int k = 0; k < nw; k++) begin
            if (k == gap_at && gap_len > 0) begin
                ld_valid = 0;
                repeat (gap_len) @(negedge clk);
                check("gap_addr_hold", eng_address, wa0 + 32'(k - 1));
                check("gap_writes", wr_addr.size() - wbase, k);
            end
            ld_valid = 1; ld_data = words[k]; ld_last = (k == nw - 1);
            t = 0;
            while (!ld_ready && t < LIM) begin @(negedge clk); t++; end
            check("ld_hs_bound", t < LIM, 1);
            @(posedge clk); #1 ld_valid = 0; ld_last = 0;
        end

        t = 0;
        while (!res_valid && t < LIM) begin @(negedge clk); t++; end
        check("res_bound", t < LIM, 1);
        exp_st = (md == M_ACC) ? 2'd0 : (md == M_REJ) ? 2'd1 : (md == M_STUCK) ? 2'd3 : 2'd2;
        exp_cc = (md == M_ACC || md == M_REJ) ? dv : 32'd0;
        check("res_status", res_status, exp_st);
        check("res_engine", res_engine, eng);
        check("res_cc", res_cc, exp_cc);
        check("busy_no_job_ready", job_ready, 0);
        check("start_ptr", eng_start_ptr, sp);
        check("end_ptr", eng_end_ptr, ep);
        if (hold > 0) begin
            stable = 1;
            repeat (hold) begin
                @(negedge clk);
                if (!res_valid || job_ready || res_status !== exp_st || res_cc !== exp_cc ||
                    res_engine !== EW'(eng)) stable = 0;
            end
            check("hold_stable", stable, 1);
        end
        res_ready = 1; @(posedge clk); #1 res_ready = 0;
        check("res_drop", res_valid, 0);

        check("write_count", wr_addr.size() - wbase, nw);
        for (int k = 0; k < nw && wbase + k < wr_addr.size(); k++) begin
            check("write_addr", wr_addr[wbase + k], wa0 + 32'(k));
            check("write_data", wr_data[wbase + k], words[k]);
            if (k > 0 && gap_len == 0)
                check("write_spacing", wr_cyc[wbase + k] - wr_cyc[wbase + k - 1], 4);
        end
        check("reset_pulses", reset_cnt - rbase, (exp_st >= 2) ? 1 : 0);
        if (md == M_STUCK) check("timeout_len", reset_cyc - last_start_cyc, TO + 2);
        check("idle_lanes", other_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb;
        for (int i = 0; i < NE; i++) begin mode[i] = M_ACC; delay[i] = 5; dval[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_cmd", eng_cmd, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_job_ready", job_ready, 0);
        check("rst_ld_ready", ld_valid & ld_ready, 0);
        rst = 1;
        @(posedge clk); #1;
        check("post_rst_job_ready", job_ready, 1);

        // reset in the middle of a word write
        cur_eng = 1; wb = wr_addr.size();
        job_valid = 1; job_engine = 2'd1; job_base_addr = 32'h40;
        while (!job_ready) @(negedge clk);
        @(posedge clk); #1 job_valid = 0;
        ld_valid = 1; ld_data = 32'h55; ld_last = 1;
        while (!ld_ready) @(negedge clk);
        @(posedge clk); #1 ld_valid = 0; ld_last = 0;
        @(posedge clk); #2 rst = 0;
        #1;
        check("midjob_rst_cmd", eng_cmd, 0);
        check("midjob_rst_res_valid", res_valid, 0);
        check("midjob_rst_addr", eng_address, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        check("midjob_rel_job_ready", job_ready, 1);
        repeat (10) @(negedge clk);
        check("midjob_no_write", wr_addr.size() - wb, 0);
        check("midjob_no_result", res_valid, 0);

        run_job(0, 32'h10, 3, M_ACC, 20, 32'h14, -1, 0, 0, 1);
        run_job(2, $urandom, 2, M_REJ, $urandom_range(1, 30), $urandom, -1, 0, 0, 0);
        run_job(1, $urandom, 3, M_ACC, 8, $urandom, 1, 7, 0, 0);
        run_job(3, $urandom, 2, M_STUCK, 0, $urandom, -1, 0, 0, 0);
        run_job(0, $urandom, 1, M_DEAD, 0, $urandom, -1, 0, 10, 0);
        run_job(1, 32'hFFFF_FFF8, 3, M_ACC, 3, $urandom, -1, 0, 0, 0);

        for (int j = 0; j < 10; j++) begin
            int md;
            md = $urandom_range(0, 3);
            if (md == M_STUCK && j % 2 == 1) md = M_ACC;
            run_job($urandom_range(0, NE - 1), $urandom, $urandom_range(1, 5), md,
                    $urandom_range(0, 40), $urandom, $urandom_range(1, 3),
                    $urandom_range(0, 6), $urandom_range(0, 4), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
